// File: rtl/prng_jump_ctrl_if.sv
// User-side and generator-side signal bundle for the xoroshiro128+ jump controller.
// The slave modport is the controller's view; the master modport is the environment's view.
interface prng_jump_ctrl_if;
   localparam int unsigned W_WORD = 64;

   logic              i_start;
   logic              i_long;
   logic              i_cg;
   logic              i_seedValid;
   logic [W_WORD-1:0] i_seedS0;
   logic [W_WORD-1:0] i_seedS1;
   logic [W_WORD-1:0] i_s0;
   logic [W_WORD-1:0] i_s1;
   logic              o_cg;
   logic              o_seedValid;
   logic [W_WORD-1:0] o_seedS0;
   logic [W_WORD-1:0] o_seedS1;
   logic              o_busy;
   logic              o_done;

   modport slave (
      input  i_start, i_long, i_cg, i_seedValid, i_seedS0, i_seedS1, i_s0, i_s1,
      output o_cg, o_seedValid, o_seedS0, o_seedS1, o_busy, o_done
   );

   modport master (
      output i_start, i_long, i_cg, i_seedValid, i_seedS0, i_seedS1, i_s0, i_s1,
      input  o_cg, o_seedValid, o_seedS0, o_seedS1, o_busy, o_done
   );
endinterface

// File: rtl/prng_jump_ctrl.sv
// Drives an external xoroshiro128+ generator through jump()/long_jump(): 128 stepping cycles
// accumulate the selected polynomial's state combination, then one cycle reseeds the generator.
module prng_jump_ctrl #(
   parameter logic [63:0] JUMP_LO  = 64'hdf900294d8f554a5,
   parameter logic [63:0] JUMP_HI  = 64'h170865df4b3201fc,
   parameter logic [63:0] LJUMP_LO = 64'hd2a98b26625eee7b,
   parameter logic [63:0] LJUMP_HI = 64'hdddf9b1090aa7ac1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   prng_jump_ctrl_if.slave        bus
);

   localparam int unsigned W_WORD = 64;
   localparam int unsigned W_POLY = 128;
   localparam int unsigned W_CNT  = 7;
   localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(W_POLY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_STEP = 2'd1,
      S_LOAD = 2'd2
   } state_t;

   state_t              r_state;
   logic [W_CNT-1:0]    r_cnt;
   logic [W_WORD-1:0]   r_acc0;
   logic [W_WORD-1:0]   r_acc1;
   logic                r_mode;
   logic                r_busy;
   logic                r_done;

   logic [W_POLY-1:0]   w_poly;
   logic                w_bit;

   // Mode picks the constant pair; cnt walks it LSB-first, word 0 before word 1.
   assign w_poly = r_mode ? {LJUMP_HI, LJUMP_LO} : {JUMP_HI, JUMP_LO};
   assign w_bit  = w_poly[r_cnt];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_acc0  <= '0;
         r_acc1  <= '0;
         r_mode  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_mode  <= bus.i_long;
                  r_cnt   <= '0;
                  r_acc0  <= '0;
                  r_acc1  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_STEP;
               end
            end
            S_STEP: begin
               if (w_bit) begin
                  r_acc0 <= r_acc0 ^ bus.i_s0;
                  r_acc1 <= r_acc1 ^ bus.i_s1;
               end
               r_cnt <= r_cnt + W_CNT'(1);
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Idle is a transparent passthrough; while jumping the controller owns the generator.
   always_comb begin
      bus.o_cg        = bus.i_cg;
      bus.o_seedValid = bus.i_seedValid;
      bus.o_seedS0    = bus.i_seedS0;
      bus.o_seedS1    = bus.i_seedS1;
      if (r_state != S_IDLE) begin
         bus.o_cg        = 1'b1;
         bus.o_seedValid = (r_state == S_LOAD);
         bus.o_seedS0    = r_acc0;
         bus.o_seedS1    = r_acc1;
      end
   end

   assign bus.o_busy = r_busy;
   assign bus.o_done = r_done;

endmodule

// File: tb/tb_prng_jump_ctrl.sv
// Bench for prng_jump_ctrl: a behavioural xoroshiro128+ generator hangs off the controller,
// and results are compared with a direct jump()/long_jump() computation.
module tb_prng_jump_ctrl;

   localparam logic [63:0] J_LO  = 64'hdf900294d8f554a5;
   localparam logic [63:0] J_HI  = 64'h170865df4b3201fc;
   localparam logic [63:0] LJ_LO = 64'hd2a98b26625eee7b;
   localparam logic [63:0] LJ_HI = 64'hdddf9b1090aa7ac1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [63:0] g0 = '0;
   logic [63:0] g1 = '0;

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] m_s0 = '0;
   logic [63:0] m_s1 = '0;
   logic [127:0] jres;
   logic [127:0] lres;

   prng_jump_ctrl_if bus ();

   prng_jump_ctrl #(
      .JUMP_LO (J_LO),
      .JUMP_HI (J_HI),
      .LJUMP_LO(LJ_LO),
      .LJUMP_HI(LJ_HI)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] xnext(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] x, na, nb;
      x  = b ^ a;
      na = ((a << 24) | (a >> 40)) ^ x ^ (x << 16);
      nb = (x << 37) | (x >> 27);
      return {nb, na};
   endfunction

   // The reference C routine: for each polynomial bit, fold in the state if set, then step.
   function automatic logic [127:0] ref_jump(input logic [63:0] a, input logic [63:0] b, input bit lng);
      logic [127:0] poly, nx;
      logic [63:0] s0, s1, t0, t1;
      poly = lng ? {LJ_HI, LJ_LO} : {J_HI, J_LO};
      s0 = a; s1 = b; t0 = '0; t1 = '0;
      for (int k = 0; k < 128; k++) begin
         if (poly[k]) begin
            t0 = t0 ^ s0;
            t1 = t1 ^ s1;
         end
         nx = xnext(s0, s1);
         s0 = nx[63:0];
         s1 = nx[127:64];
      end
      return {t1, t0};
   endfunction

   // Generator model: seed load has priority over stepping.
   always @(posedge clk) begin
      if (bus.o_seedValid) begin
         g0 <= bus.o_seedS0;
         g1 <= bus.o_seedS1;
      end else if (bus.o_cg) begin
         {g1, g0} <= xnext(g0, g1);
      end
   end
   assign bus.i_s0 = g0;
   assign bus.i_s1 = g1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts a jump in the current cycle and runs until o_done (or a 140-cycle bound).
   task automatic do_jump(input string tag, input logic [63:0] s0, input logic [63:0] s1,
                          input bit seed_it, input bit lng, input bit collide, input bit noise);
      logic [63:0] b0, b1;
      logic [127:0] exp, load;
      int done_c, busy_n, busy_first, busy_last, cg_n, sv_n, sv_c;
      b0 = seed_it ? s0 : m_s0;
      b1 = seed_it ? s1 : m_s1;
      exp = ref_jump(b0, b1, lng);
      done_c = 0; busy_n = 0; busy_first = 0; busy_last = 0; cg_n = 0; sv_n = 0; sv_c = 0;
      load = '0;
      bus.i_start     = 1'b1;
      bus.i_long      = lng;
      bus.i_cg        = 1'b0;
      bus.i_seedValid = seed_it;
      bus.i_seedS0    = s0;
      bus.i_seedS1    = s1;
      #1;
      chk({tag, " start_busy"}, 128'(bus.o_busy), 128'(0));
      chk({tag, " start_seedValid"}, 128'(bus.o_seedValid), 128'(seed_it));
      step();
      bus.i_long = ~lng;
      for (int c = 1; c <= 140 && done_c == 0; c++) begin
         if (noise && c <= 129) begin
            bus.i_cg        = 1'($urandom_range(0, 1));
            bus.i_seedValid = 1'($urandom_range(0, 1));
            bus.i_seedS0    = {$urandom, $urandom};
            bus.i_seedS1    = {$urandom, $urandom};
            bus.i_long      = 1'($urandom_range(0, 1));
         end else begin
            bus.i_cg        = 1'b0;
            bus.i_seedValid = 1'b0;
         end
         bus.i_start = (c <= 129) &&
                       (collide ? (c == 5 || c == 100) : (noise && $urandom_range(0, 3) == 0));
         #1;
         if (bus.o_busy) begin
            busy_n++;
            if (busy_first == 0) busy_first = c;
            busy_last = c;
         end
         if (bus.o_cg) cg_n++;
         if (bus.o_seedValid) begin
            sv_n++;
            sv_c = c;
            load = {bus.o_seedS1, bus.o_seedS0};
         end
         if (bus.o_done) done_c = c;
         else step();
      end
      bus.i_start = 1'b0;
      chk({tag, " done_cycle"}, 128'(done_c), 128'(130));
      chk({tag, " busy_count"}, 128'(busy_n), 128'(129));
      chk({tag, " busy_first"}, 128'(busy_first), 128'(1));
      chk({tag, " busy_last"}, 128'(busy_last), 128'(129));
      chk({tag, " cg_count"}, 128'(cg_n), 128'(129));
      chk({tag, " seedValid_count"}, 128'(sv_n), 128'(1));
      chk({tag, " seedValid_cycle"}, 128'(sv_c), 128'(129));
      chk({tag, " load_seed"}, load, exp);
      chk({tag, " gen_state"}, {g1, g0}, exp);
      m_s0 = exp[63:0];
      m_s1 = exp[127:64];
   endtask

   initial begin
      int sv_n, done_n;
      bus.i_start = 1'b1;
      bus.i_long = 1'b1;
      bus.i_cg = 1'b0;
      bus.i_seedValid = 1'b0;
      bus.i_seedS0 = '0;
      bus.i_seedS1 = '0;
      rst = 1'b1;
      step(); step(); step();
      rst = 1'b0;
      bus.i_start = 1'b0;
      #1;
      chk("reset busy", 128'(bus.o_busy), 128'(0));
      chk("reset done", 128'(bus.o_done), 128'(0));

      bus.i_cg = 1'b1;
      bus.i_seedValid = 1'b1;
      bus.i_seedS0 = 64'h1;
      bus.i_seedS1 = 64'h2;
      #1;
      chk("pass cg", 128'(bus.o_cg), 128'(1));
      chk("pass seedValid", 128'(bus.o_seedValid), 128'(1));
      chk("pass seedS0", 128'(bus.o_seedS0), 128'(64'h1));
      chk("pass seedS1", 128'(bus.o_seedS1), 128'(64'h2));
      chk("pass busy", 128'(bus.o_busy), 128'(0));
      bus.i_cg = 1'b0;
      bus.i_seedValid = 1'b0;
      step();
      chk("pass idle cg", 128'(bus.o_cg), 128'(0));

      do_jump("zero", 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("zero state", {g1, g0}, 128'(0));
      step();

      do_jump("jump", 64'h0123456789abcdef, 64'hfedcba9876543210, 1'b1, 1'b0, 1'b0, 1'b0);
      jres = {g1, g0};
      step(); step();

      do_jump("ljump", 64'h0123456789abcdef, 64'hfedcba9876543210, 1'b1, 1'b1, 1'b0, 1'b0);
      lres = {g1, g0};
      n_cmp++;
      assert (lres !== ref_jump(64'h0123456789abcdef, 64'hfedcba9876543210, 1'b0)) else begin
         n_err++;
         $error("FAIL ljump_differs observed=%h expected_not=%h", lres, jres);
      end
      step();

      do_jump("collide", 64'h0123456789abcdef, 64'hfedcba9876543210, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("collide vs jump", {g1, g0}, ref_jump(64'h0123456789abcdef, 64'hfedcba9876543210, 1'b0));

      // Restart in the o_done cycle, continuing from the jumped state.
      do_jump("b2b", 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();

      // Abort: reset is sampled at the end of cycle 60.
      bus.i_start = 1'b1;
      bus.i_long = 1'b0;
      bus.i_seedValid = 1'b1;
      bus.i_seedS0 = 64'h0123456789abcdef;
      bus.i_seedS1 = 64'hfedcba9876543210;
      step();
      bus.i_start = 1'b0;
      bus.i_seedValid = 1'b0;
      sv_n = 0;
      done_n = 0;
      for (int c = 1; c <= 60; c++) begin
         rst = (c == 60);
         #1;
         if (bus.o_seedValid) sv_n++;
         if (bus.o_done) done_n++;
         step();
      end
      rst = 1'b0;
      #1;
      chk("abort busy", 128'(bus.o_busy), 128'(0));
      for (int c = 0; c < 150; c++) begin
         if (bus.o_seedValid) sv_n++;
         if (bus.o_done) done_n++;
         step();
      end
      chk("abort seedValid", 128'(sv_n), 128'(0));
      chk("abort done", 128'(done_n), 128'(0));

      do_jump("after_abort", 64'hdeadbeefcafef00d, 64'h0badc0de12345678, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         do_jump($sformatf("rand%0d", r), {$urandom, $urandom}, {$urandom, $urandom},
                 (r % 2) == 0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
         if (r % 3 == 1) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/prng_jump_ctrl.md
PRNG_JUMP_CTRL -- requirements
Module: prng_jump_ctrl

Interface
REQ-001 SHALL have parameter JUMP_LO, default 64'hdf900294d8f554a5, meaning jump() polynomial word 0.
REQ-002 SHALL have parameter JUMP_HI, default 64'h170865df4b3201fc, meaning jump() polynomial word 1.
REQ-003 SHALL have parameter LJUMP_LO, default 64'hd2a98b26625eee7b, meaning long_jump() word 0.
REQ-004 SHALL have parameter LJUMP_HI, default 64'hdddf9b1090aa7ac1, meaning long_jump() word 1.
REQ-005 SHALL use one clock, i_clk; reset i_rst is synchronous and active-high.
REQ-006 SHALL have ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  request a jump (sampled in IDLE only)
- i_long  in  1  with i_start: 1 = long_jump, 0 = jump
- i_cg  in  1  user PRNG step enable (passthrough)
- i_seedValid  in  1  user seed strobe (passthrough)
- i_seedS0, i_seedS1  in  64 each  user seed (passthrough)
- i_s0, i_s1  in  64 each  current state from xoroshiro128+ generator
- o_cg  out  1  generator clock-gate enable
- o_seedValid  out  1  generator seed strobe
- o_seedS0, o_seedS1  out  64 each  generator seed value
- o_busy  out  1  jump in progress
- o_done  out  1  one-cycle pulse, jump complete

Function
REQ-007 SHALL implement states IDLE, STEP, LOAD; registered 7-bit counter cnt; 128-bit accumulator {acc1, acc0}; latched mode bit.
REQ-008 IDLE: o_cg=i_cg, o_seedValid=i_seedValid, o_seedS0=i_seedS0, o_seedS1=i_seedS1, o_busy=0.
REQ-009 IDLE with i_start=1: latch i_long, clear acc and cnt, go to STEP next cycle; that cycle's outputs remain passthrough (same-cycle user seed is applied, and the jump acts on it).
REQ-010 STEP: o_cg=1, o_seedValid=0, o_busy=1; user i_cg/i_seedValid ignored (dropped, not queued).
REQ-011 STEP: polynomial bit p = cnt<64 ? LO[cnt] : HI[cnt-64] from the selected constant pair; if p=1, acc0^=i_s0 and acc1^=i_s1 at the clock edge.
REQ-012 STEP: cnt increments every cycle; at cnt=127 go to LOAD; exactly 128 STEP cycles.
REQ-013 LOAD: o_cg=1, o_seedValid=1, o_seedS0=acc0, o_seedS1=acc1, o_busy=1; then go to IDLE.
REQ-014 o_done SHALL be registered, high for exactly the first IDLE cycle after LOAD.
REQ-015 Latency: i_start accepted in cycle 0 -> STEP cycles 1..128 -> LOAD cycle 129 -> o_done=1 in cycle 130, with generator state equal to the jumped state.
REQ-016 i_start while o_busy=1 SHALL be ignored; i_start in the o_done cycle SHALL be accepted normally.
REQ-017 i_long SHALL be sampled only at acceptance; later changes have no effect.
REQ-018 In STEP and LOAD, o_seedS0/o_seedS1 SHALL equal acc0/acc1 (don't-care to generator in STEP, but deterministic).

Reset
REQ-019 i_rst=1 SHALL force state=IDLE, cnt=0, acc=0, mode=0, o_done=0, o_busy=0 at the next edge; outputs then follow REQ-008.
REQ-020 Reset mid-jump SHALL abort without LOAD; generator state is left partially advanced; no o_done.

Verification
REQ-021 Passthrough: IDLE, i_cg=1, i_seedValid=1, i_seedS0=64'h1, i_seedS1=64'h2 -> o_cg=1, o_seedValid=1, o_seedS0=64'h1, o_seedS1=64'h2, o_busy=0 same cycle.
REQ-022 Zero state: generator seeded 0/0, i_start, i_long=0 -> o_busy high cycles 1..129, o_seedValid only in cycle 129 with seeds 0/0, o_done in cycle 130, state 0/0.
REQ-023 Jump: seed s0=64'h0123456789abcdef, s1=64'hfedcba9876543210, i_start, i_long=0 -> generator state at o_done equals C reference jump() result; o_cg=1 for exactly 129 cycles.
REQ-024 Long jump: same seed, i_long=1 -> state equals C reference long_jump() result; differs from REQ-023 result.
REQ-025 Collisions: i_start pulsed at cycles 5 and 100 of a busy jump, and i_cg=0 throughout -> both ignored, one o_done, result identical to REQ-023.
REQ-026 Abort: i_rst at cycle 60 -> o_busy=0 next cycle, o_seedValid never 1, no o_done; new i_start afterwards completes in 130 cycles.
